// File: rtl/npc_fetch_seq.sv
// -----------------------------------------------------------------------------
// npc_fetch_seq
//   Sequential next-PC unit. Owns the architectural PC, issues fetch requests to
//   instruction memory over a valid/ready handshake, applies redirects coming
//   from later pipeline stages (branch, jump-immediate, jump-register),
//   vectors to the exception handler, supports halt and counts committed
//   fetches with a saturating counter.
//
//   Configuration macro: NPC_ALIGN_CHECK_EN
//     defined   : a misaligned redirect target is not loaded. The PC vectors to
//                 EXC_VEC instead, and align_err pulses for one cycle.
//     undefined : the target is loaded with bits [1:0] forced to 00, and
//                 align_err is tied low.
//
//   The rst port is asynchronous and active low.
// -----------------------------------------------------------------------------
module npc_fetch_seq #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_pc,
    input  logic             redirect_valid,
    input  logic [1:0]       npc_op,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic [25:0]      imm,
    input  logic [WIDTH-1:0] addr,
    input  logic             exc_valid,
    input  logic             halt,
    output logic             kill,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             align_err
);

    // Vectors truncated (or zero-extended) to the address width.
    localparam logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(32'd4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // Redirect operation encodings.
    localparam logic [1:0] OP_PLUS4    = 2'b00;
    localparam logic [1:0] OP_BRANCH   = 2'b01;
    localparam logic [1:0] OP_JUMP_IMM = 2'b10;
    localparam logic [1:0] OP_JUMP_REG = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Control-transfer target for a redirecting instruction at rpc.
    // Branch offsets are word offsets, so they are sign-extended and scaled by 4.
    // Jump-immediate keeps the region bits of rpc+4 above bit 27.
    function automatic logic [WIDTH-1:0] redirect_target(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] rpc,
        input logic [25:0]      im,
        input logic [WIDTH-1:0] reg_tgt
    );
        logic [WIDTH-1:0] rp4;
        logic [WIDTH-1:0] boff;
        logic [WIDTH-1:0] tgt;
        rp4  = rpc + PC_STEP;
        boff = {{(WIDTH-18){im[15]}}, im[15:0], 2'b00};
        case (op)
            OP_PLUS4:    tgt = rp4;
            OP_BRANCH:   tgt = rp4 + boff;
            OP_JUMP_IMM: tgt = {rp4[WIDTH-1:28], im, 2'b00};
            OP_JUMP_REG: tgt = reg_tgt;
            default:     tgt = rp4;
        endcase
        return tgt;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_next_s;
    logic             if_valid_r;
    logic             valid_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             align_err_r;
    logic             align_next_s;
    logic             accept_s;
    logic             kill_s;
    logic [WIDTH-1:0] target_s;

    // Handshake, squash, and redirect target decode.
    always_comb begin
        accept_s = if_valid_r & if_ready;
        kill_s   = exc_valid | redirect_valid;
        target_s = redirect_target(npc_op, redirect_pc, imm, addr);
    end

    // Next PC selection: exception, then redirect, then sequential advance, else hold.
    always_comb begin
        pc_next_s    = pc_r;
        align_next_s = 1'b0;
        if (exc_valid) begin
            pc_next_s = EXC_PC;
        end else if (redirect_valid) begin
`ifdef NPC_ALIGN_CHECK_EN
            if (target_s[1:0] != 2'b00) begin
                pc_next_s    = EXC_PC;
                align_next_s = 1'b1;
            end else begin
                pc_next_s = target_s;
            end
`else
            pc_next_s = target_s & ALIGN_MASK;
`endif
        end else if (accept_s) begin
            pc_next_s = pc_r + PC_STEP;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Sequencer next state. An exception forces RUN so that the handler is fetched.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                if (halt && !exc_valid) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!halt || exc_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: begin
                state_next_s = ST_BOOT;
            end
        endcase
        valid_next_s = (state_next_s == ST_RUN);
    end

    // Saturating count of fetches that were accepted and not squashed.
    always_comb begin
        cnt_next_s = cnt_r;
        if (accept_s && !kill_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Architectural state and registered request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_BOOT;
            pc_r        <= RESET_PC;
            if_valid_r  <= 1'b0;
            cnt_r       <= '0;
            align_err_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            if_valid_r  <= valid_next_s;
            cnt_r       <= cnt_next_s;
            align_err_r <= align_next_s;
        end
    end

    assign if_valid  = if_valid_r;
    assign if_pc     = pc_r;
    assign kill      = kill_s;
    assign fetch_cnt = cnt_r;
`ifdef NPC_ALIGN_CHECK_EN
    assign align_err = align_err_r;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_npc_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_npc_fetch_seq
//   Scoreboard bench for npc_fetch_seq. Each tick pushes the expected
//   post-edge outputs. After the clock edge, the entry is popped and compared
//   with the DUT outputs. The counter width is reduced to 4 bits so that
//   saturation can be reached quickly.
// -----------------------------------------------------------------------------
module tb_npc_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ready;
    logic        redirect_valid;
    logic [1:0]  npc_op;
    logic [31:0] redirect_pc;
    logic [25:0] imm;
    logic [31:0] addr;
    logic        exc_valid;
    logic        halt;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        kill;
    logic [3:0]  fetch_cnt;
    logic        align_err;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic        ae;
    } exp_t;

    exp_t sb[$];

    logic [31:0] e_pc;
    logic [3:0]  e_cnt;

    always #5 clk = ~clk;

    npc_fetch_seq #(
        .WIDTH    (32),
        .RESET_VEC(32'h0000_3000),
        .EXC_VEC  (32'h0000_4180),
        .CNT_W    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .redirect_valid(redirect_valid),
        .npc_op        (npc_op),
        .redirect_pc   (redirect_pc),
        .imm           (imm),
        .addr          (addr),
        .exc_valid     (exc_valid),
        .halt          (halt),
        .kill          (kill),
        .fetch_cnt     (fetch_cnt),
        .align_err     (align_err)
    );

    task automatic clear_inputs();
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        npc_op         = 2'b00;
        redirect_pc    = 32'h0;
        imm            = 26'h0;
        addr           = 32'h0;
        exc_valid      = 1'b0;
        halt           = 1'b0;
    endtask

    // Check kill before the edge, queue the expected post-edge outputs, then pop and compare them after the edge.
    task automatic tick(input string name, input logic e_kill, input logic e_v, input logic e_ae);
        exp_t e;
        #1;
        checks++;
        if (kill !== e_kill) $display("FAIL %s kill: got %0b expected %0b", name, kill, e_kill);
        else passes++;
        e.name = name;
        e.v    = e_v;
        e.pc   = e_pc;
        e.cnt  = e_cnt;
        e.ae   = e_ae;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (if_valid !== e.v) $display("FAIL %s if_valid: got %0b expected %0b", e.name, if_valid, e.v);
        else passes++;
        checks++;
        if (if_pc !== e.pc) $display("FAIL %s if_pc: got %h expected %h", e.name, if_pc, e.pc);
        else passes++;
        checks++;
        if (fetch_cnt !== e.cnt) $display("FAIL %s fetch_cnt: got %0d expected %0d", e.name, fetch_cnt, e.cnt);
        else passes++;
        checks++;
        if (align_err !== e.ae) $display("FAIL %s align_err: got %0b expected %0b", e.name, align_err, e.ae);
        else passes++;
    endtask

    task automatic test_reset();
        checks++;
        if (if_valid !== 1'b0) $display("FAIL reset if_valid: got %0b expected 0", if_valid);
        else passes++;
        checks++;
        if (if_pc !== 32'h0000_3000) $display("FAIL reset if_pc: got %h expected 00003000", if_pc);
        else passes++;
        checks++;
        if (fetch_cnt !== 4'd0) $display("FAIL reset fetch_cnt: got %0d expected 0", fetch_cnt);
        else passes++;
        checks++;
        if (align_err !== 1'b0) $display("FAIL reset align_err: got %0b expected 0", align_err);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0000_3000)
            $display("FAIL boot_state: got valid=%0b pc=%h expected valid=0 pc=00003000", if_valid, if_pc);
        else passes++;
    endtask

    task automatic test_boot_fetch();
        if_ready = 1'b1;
        e_pc = 32'h0000_3000; e_cnt = 4'd0; tick("boot_to_run", 1'b0, 1'b1, 1'b0);
        e_pc = 32'h0000_3004; e_cnt = 4'd1; tick("fetch_3000", 1'b0, 1'b1, 1'b0);
        e_pc = 32'h0000_3008; e_cnt = 4'd2; tick("fetch_3004", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        if_ready = 1'b0;
        tick("stall_0", 1'b0, 1'b1, 1'b0);
        tick("stall_1", 1'b0, 1'b1, 1'b0);
        if_ready = 1'b1;
        e_pc = 32'h0000_300C; e_cnt = 4'd3; tick("stall_release", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_branch();
        redirect_valid = 1'b1; npc_op = 2'b01;
        redirect_pc = 32'h0000_3010; imm = 26'h000_FFFE;
        e_pc = 32'h0000_300C; tick("branch_back", 1'b1, 1'b1, 1'b0);
        redirect_pc = 32'h0000_3000; imm = 26'h000_0010;
        e_pc = 32'h0000_3044; tick("branch_fwd", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_jump_imm();
        redirect_valid = 1'b1; npc_op = 2'b10;
        redirect_pc = 32'hF000_0000; imm = 26'h000_0040;
        e_pc = 32'hF000_0100; tick("jump_imm", 1'b1, 1'b1, 1'b0);
        redirect_valid = 1'b0;
        e_pc = 32'hF000_0104; e_cnt = 4'd4; tick("after_jump", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_exc_redirect();
        exc_valid = 1'b1; redirect_valid = 1'b1; npc_op = 2'b11;
        addr = 32'h0000_5000; halt = 1'b1;
        e_pc = 32'h0000_4180; tick("exc_over_redirect", 1'b1, 1'b1, 1'b0);
        exc_valid = 1'b0; redirect_valid = 1'b0; halt = 1'b0; if_ready = 1'b0;
        tick("exc_hold", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_halt();
        halt = 1'b1; if_ready = 1'b1;
        e_pc = 32'h0000_4184; e_cnt = 4'd5; tick("halt_enter", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick("halt_hold", 1'b0, 1'b0, 1'b0);
        halt = 1'b0;
        tick("halt_exit", 1'b0, 1'b1, 1'b0);
        e_pc = 32'h0000_4188; e_cnt = 4'd6; tick("halt_resume", 1'b0, 1'b1, 1'b0);
        halt = 1'b1; if_ready = 1'b0;
        tick("halt_again", 1'b0, 1'b0, 1'b0);
        exc_valid = 1'b1;
        e_pc = 32'h0000_4180; tick("halt_exc_wake", 1'b1, 1'b1, 1'b0);
        exc_valid = 1'b0; halt = 1'b0;
    endtask

    task automatic test_wrap();
        if_ready = 1'b1; redirect_valid = 1'b1; npc_op = 2'b11; addr = 32'hFFFF_FFFC;
        e_pc = 32'hFFFF_FFFC; tick("jump_reg_top", 1'b1, 1'b1, 1'b0);
        redirect_valid = 1'b0;
        e_pc = 32'h0000_0000; e_cnt = 4'd7; tick("pc_wrap", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_align();
        redirect_valid = 1'b1; npc_op = 2'b11; addr = 32'h0000_3006;
`ifdef NPC_ALIGN_CHECK_EN
        e_pc = 32'h0000_4180; tick("jump_reg_misalign", 1'b1, 1'b1, 1'b1);
`else
        e_pc = 32'h0000_3004; tick("jump_reg_misalign", 1'b1, 1'b1, 1'b0);
`endif
        redirect_valid = 1'b0; if_ready = 1'b0;
        tick("align_clear", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        if_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            e_pc = e_pc + 32'd4;
            if (e_cnt != 4'hF) e_cnt = e_cnt + 4'd1;
            tick("saturate", 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        if_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0) $display("FAIL midreset if_valid: got %0b expected 0", if_valid);
        else passes++;
        checks++;
        if (if_pc !== 32'h0000_3000) $display("FAIL midreset if_pc: got %h expected 00003000", if_pc);
        else passes++;
        checks++;
        if (fetch_cnt !== 4'd0) $display("FAIL midreset fetch_cnt: got %0d expected 0", fetch_cnt);
        else passes++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        e_pc = 32'h0000_3000; e_cnt = 4'd0; tick("post_reset_boot", 1'b0, 1'b1, 1'b0);
        e_pc = 32'h0000_3004; e_cnt = 4'd1; tick("post_reset_fetch", 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        e_pc = 32'h0000_3000;
        e_cnt = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_boot_fetch();
        test_stall();
        test_branch();
        test_jump_imm();
        test_exc_redirect();
        test_halt();
        test_wrap();
        test_align();
        test_saturation();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
